// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo -- buffered 8N1 UART transmitter.
//
// Bytes pushed by the upstream I/O peripheral are queued in a circular FIFO
// and serialised LSB first onto txd (start bit 0, eight data bits, stop bit 1),
// each bit lasting DIV = round(CLK_FREQ / BAUD) sysclk cycles. Frames run
// back to back while the FIFO holds data.
//
// Ports:
//   sysclk    in   system clock (only clock)
//   reset     in   synchronous, active-high reset
//   wr_data   in   [7:0] byte to enqueue
//   wr_en     in   push strobe, one push per cycle while high
//   full      out  FIFO holds FIFO_DEPTH entries
//   empty     out  FIFO holds no entries
//   level     out  [$clog2(FIFO_DEPTH+1)-1:0] FIFO occupancy
//   overflow  out  sticky: a push was dropped because the FIFO was full
//   ovf_clr   in   clears overflow (a same-cycle drop takes priority)
//   tx_active out  high while start, data or stop bit is on the line
//   txd       out  serial output, idles high
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                              sysclk,
  input  logic                              reset,
  input  logic [7:0]                        wr_data,
  input  logic                              wr_en,
  output logic                              full,
  output logic                              empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   level,
  output logic                              overflow,
  input  logic                              ovf_clr,
  output logic                              tx_active,
  output logic                              txd
);

  localparam int unsigned DIV = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned LW  = $clog2(FIFO_DEPTH + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  // FIFO storage and pointers (one bit wider than the index)
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;

  // Serialiser state
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift, shift_n;
  logic          txd_c;
  logic          active_c;
  logic          cnt_last;

  assign count = wr_ptr - rd_ptr;
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign level = LW'(count);

  // full is sampled before any same-cycle pop, so a push at a full FIFO is
  // always dropped even when the serialiser frees an entry on that edge.
  assign push     = wr_en && !full;
  assign cnt_last = (cnt == CNT_LAST);

  always_ff @(posedge sysclk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      txd       <= 1'b1;
      tx_active <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + (AW + 1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (AW + 1)'(1);
      end
      if (wr_en && full) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_idx_n;
      shift     <= shift_n;
      // Line outputs are registered from the current state, so the line
      // trails the FSM by one cycle and every bit still lasts DIV cycles.
      txd       <= txd_c;
      tx_active <= active_c;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CW'(1);
    bit_idx_n = bit_idx;
    shift_n   = shift;
    pop       = 1'b0;
    txd_c     = 1'b1;
    active_c  = 1'b1;

    unique case (state)
      IDLE: begin
        active_c = 1'b0;
        cnt_n    = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr[AW-1:0]];
          state_n = START;
        end
      end
      START: begin
        txd_c = 1'b0;
        if (cnt_last) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = DATA;
        end
      end
      DATA: begin
        txd_c = shift[0];
        if (cnt_last) begin
          cnt_n   = '0;
          shift_n = shift >> 1;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        if (cnt_last) begin
          cnt_n = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_n = mem[rd_ptr[AW-1:0]];
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo with DIV = 10 and a 4-entry FIFO.
module tb_uart_tx_fifo;

  localparam int DIV = 10;

  logic       sysclk;
  logic       reset;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       full;
  logic       empty;
  logic [2:0] level;
  logic       overflow;
  logic       ovf_clr;
  logic       tx_active;
  logic       txd;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] exp_bytes[$];

  uart_tx_fifo #(
    .CLK_FREQ  (1000),
    .BAUD      (100),
    .FIFO_DEPTH(4)
  ) dut (
    .sysclk   (sysclk),
    .reset    (reset),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow),
    .ovf_clr  (ovf_clr),
    .tx_active(tx_active),
    .txd      (txd)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // bit t = line value during bit slot t (0 = start)
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] frame_of(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  // Walks the expected line waveform for every byte in exp_bytes, starting
  // 'skip' cycles after the first start bit appeared on txd.
  task automatic run_frames(input string name, input int skip);
    logic [9:0] f;
    for (int i = skip; i < exp_bytes.size() * 10 * DIV; i++) begin
      f = frame_of(exp_bytes[i / (10 * DIV)]);
      check({name, "_txd"}, 32'(txd), 32'(f[(i % (10 * DIV)) / DIV]));
      check({name, "_act"}, 32'(tx_active), 32'd1);
      tick();
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    wr_data = b;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
  endtask

  initial begin
    int bad_cycles;

    vecs[0] = '{8'h55, 10'b1010101010};
    vecs[1] = '{8'hA3, 10'b1101000110};
    vecs[2] = '{8'h0F, 10'b1000011110};
    vecs[3] = '{8'hFF, 10'b1111111110};
    vecs[4] = '{8'h00, 10'b1000000000};

    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_data = '0;
    ovf_clr = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset / idle
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_act", 32'(tx_active), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    bad_cycles = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (txd !== 1'b1 || tx_active !== 1'b0 || empty !== 1'b1 || level !== 3'd0) bad_cycles++;
    end
    check("idle_hold", 32'(bad_cycles), 32'd0);

    // Single-byte frames from the vector table
    for (int v = 0; v < 5; v++) begin
      push_byte(vecs[v].data);                       // edge N
      check("vec_empty_n", 32'(empty), 32'd0);
      check("vec_level_n", 32'(level), 32'd1);
      check("vec_txd_n", 32'(txd), 32'd1);
      tick();                                        // edge N+1: pop
      check("vec_empty_n1", 32'(empty), 32'd1);
      check("vec_level_n1", 32'(level), 32'd0);
      check("vec_txd_n1", 32'(txd), 32'd1);
      check("vec_act_n1", 32'(tx_active), 32'd0);
      tick();                                        // edge N+2: start bit
      for (int t = 0; t < 10; t++) begin
        for (int c = 0; c < DIV; c++) begin
          check("vec_txd", 32'(txd), 32'(vecs[v].frame[t]));
          check("vec_act", 32'(tx_active), 32'd1);
          tick();
        end
      end
      check("vec_act_end", 32'(tx_active), 32'd0);  // edge N+102
      check("vec_txd_end", 32'(txd), 32'd1);
    end

    // Burst of three back-to-back frames
    push_byte(8'hA3);
    check("burst_lvl0", 32'(level), 32'd1);
    push_byte(8'h0F);
    check("burst_lvl1", 32'(level), 32'd1);
    push_byte(8'hFF);
    check("burst_lvl2", 32'(level), 32'd2);
    exp_bytes = '{8'hA3, 8'h0F, 8'hFF};
    run_frames("burst", 0);
    check("burst_act_end", 32'(tx_active), 32'd0);
    check("burst_empty_end", 32'(empty), 32'd1);

    // Fill to overflow: six pushes, one dropped
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    push_byte(8'h44);
    push_byte(8'h55);                                // edge N+4
    check("ovf_full", 32'(full), 32'd1);
    check("ovf_level4", 32'(level), 32'd4);
    check("ovf_not_yet", 32'(overflow), 32'd0);
    push_byte(8'h66);                                // edge N+5: dropped
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_level_hold", 32'(level), 32'd4);
    exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    run_frames("ovf", 3);
    check("ovf_act_end", 32'(tx_active), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);
    check("ovf_empty_end", 32'(empty), 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Push while full coinciding with the stop-bit pop; set beats clear
    push_byte(8'h01);                                // edge N
    push_byte(8'h02);
    push_byte(8'h03);
    push_byte(8'h04);
    push_byte(8'h05);                                // edge N+4
    for (int i = 0; i < 96; i++) tick();             // edge N+100
    check("pwf_full", 32'(full), 32'd1);
    check("pwf_level", 32'(level), 32'd4);
    check("pwf_ovf0", 32'(overflow), 32'd0);
    wr_data = 8'h77;
    wr_en   = 1'b1;
    ovf_clr = 1'b1;
    tick();                                          // edge N+101: pop + dropped push
    wr_en   = 1'b0;
    ovf_clr = 1'b0;
    check("pwf_ovf1", 32'(overflow), 32'd1);
    check("pwf_level3", 32'(level), 32'd3);
    check("pwf_notfull", 32'(full), 32'd0);
    tick();                                          // edge N+102: frame 2 start
    exp_bytes = '{8'h02, 8'h03, 8'h04, 8'h05};
    run_frames("pwf", 0);
    check("pwf_act_end", 32'(tx_active), 32'd0);
    check("pwf_empty_end", 32'(empty), 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("pwf_ovf_clr", 32'(overflow), 32'd0);

    // Reset in the middle of data bit 3 with two bytes queued
    push_byte(8'hF0);                                // edge N
    push_byte(8'h12);
    push_byte(8'h34);                                // edge N+2
    check("rmid_level", 32'(level), 32'd2);
    for (int i = 0; i < 44; i++) tick();             // edge N+46, bit 3 slot
    check("rmid_act_pre", 32'(tx_active), 32'd1);
    check("rmid_txd_pre", 32'(txd), 32'd0);
    reset = 1'b1;
    tick();                                          // edge N+47
    reset = 1'b0;
    check("rmid_txd", 32'(txd), 32'd1);
    check("rmid_act", 32'(tx_active), 32'd0);
    tick();
    check("rmid_empty", 32'(empty), 32'd1);
    check("rmid_level0", 32'(level), 32'd0);
    bad_cycles = 0;
    for (int i = 0; i < 250; i++) begin
      tick();
      if (txd !== 1'b1 || tx_active !== 1'b0) bad_cycles++;
    end
    check("rmid_silent", 32'(bad_cycles), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
